// File: rtl/gpu_stencil_pkg.sv
// gpu_stencil_pkg: shared constants, clear FSM states and address split helpers for the stencil bank array.
package gpu_stencil_pkg;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_BANK_BITS = 3;
  localparam int DEF_CNT_W = 16;
  localparam int NBANK = 1 << DEF_BANK_BITS;
  localparam int ROW_W = DEF_ADDR_W - DEF_BANK_BITS;
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} clr_state_e;
  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int bb);
    return addr & ((32'd1 << bb) - 32'd1);
  endfunction
  function automatic logic [31:0] row_of(input logic [31:0] addr, input int bb);
    return addr >> bb;
  endfunction
endpackage

// File: rtl/gpu_stencil_bank.sv
// gpu_stencil_bank: single-port stencil bank RAM with write enable and registered read.
module gpu_stencil_bank
  import gpu_stencil_pkg::*;
#(
  parameter int DW = DEF_DATA_W,
  parameter int RW = ROW_W
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [RW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [1 << RW];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem[addr_i] <= wdata_i;
      else rdata_q <= mem[addr_i];
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/gpu_stencil_bank_array.sv
// gpu_stencil_bank_array: banked stencil store with back-pressure arbitration,
// pipelined masked read-modify-write and a bulk-clear sequencer.
module gpu_stencil_bank_array
  import gpu_stencil_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BANK_BITS = DEF_BANK_BITS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] wr_mask_i,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] clr_value_i,
  output logic              busy_o,
  output logic              clr_done_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  localparam int NB = 1 << BANK_BITS;
  localparam int RW = ADDR_W - BANK_BITS;
  clr_state_e state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d, wrow, rrow, rmw_row_q, rmw_row_d;
  logic [BANK_BITS-1:0] wb, rb, rmw_bank_q, rmw_bank_d, rd_bank_q, rd_bank_d;
  logic [DATA_W-1:0] clrv_q, clrv_d, rmw_data_q, rmw_data_d, rmw_mask_q, rmw_mask_d, rd_hold_q, rd_hold_d;
  logic done_q, done_d, rmw_v_q, rmw_v_d, rd_v_q, rd_v_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic wr_fire, rd_fire, full, part;
  logic en [NB];
  logic we [NB];
  logic [RW-1:0] ba [NB];
  logic [DATA_W-1:0] bw [NB];
  logic [DATA_W-1:0] br [NB];
  assign wb = BANK_BITS'(bank_of(32'(wr_addr_i), BANK_BITS));
  assign rb = BANK_BITS'(bank_of(32'(rd_addr_i), BANK_BITS));
  assign wrow = RW'(row_of(32'(wr_addr_i), BANK_BITS));
  assign rrow = RW'(row_of(32'(rd_addr_i), BANK_BITS));
  assign busy_o = state_q != IDLE;
  assign wr_ready_o = !busy_o && !clr_i && !(rmw_v_q && wb == rmw_bank_q);
  assign rd_ready_o = !busy_o && !clr_i && !(wr_valid_i && wr_ready_o && rb == wb) && !(rmw_v_q && rb == rmw_bank_q);
  assign wr_fire = wr_valid_i && wr_ready_o;
  assign rd_fire = rd_valid_i && rd_ready_o;
  assign full = &wr_mask_i;
  assign part = wr_fire && |wr_mask_i && !full;
  assign rd_valid_o = rd_v_q;
  assign rd_data_o = rd_v_q ? br[rd_bank_q] : rd_hold_q;
  assign clr_done_o = done_q;
  assign stall_cnt_o = stall_q;
  // A partial write first reads its row; the merge happens next cycle from the bank's read register.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      en[b] = 1'b0;
      we[b] = 1'b0;
      ba[b] = wrow;
      bw[b] = wr_data_i;
      if (rmw_v_q && rmw_bank_q == BANK_BITS'(b)) begin
        en[b] = 1'b1;
        we[b] = 1'b1;
        ba[b] = rmw_row_q;
        bw[b] = (rmw_data_q & rmw_mask_q) | (br[b] & ~rmw_mask_q);
      end else if (state_q == CLEAR) begin
        en[b] = 1'b1;
        we[b] = 1'b1;
        ba[b] = cnt_q;
        bw[b] = clrv_q;
      end else if (wr_fire && |wr_mask_i && wb == BANK_BITS'(b)) begin
        en[b] = 1'b1;
        we[b] = full;
      end else if (rd_fire && rb == BANK_BITS'(b)) begin
        en[b] = 1'b1;
        ba[b] = rrow;
      end
    end
  end
  always_comb begin
    rmw_v_d = part;
    rmw_bank_d = part ? wb : rmw_bank_q;
    rmw_row_d = part ? wrow : rmw_row_q;
    rmw_data_d = part ? wr_data_i : rmw_data_q;
    rmw_mask_d = part ? wr_mask_i : rmw_mask_q;
    rd_v_d = rd_fire;
    rd_bank_d = rd_fire ? rb : rd_bank_q;
    rd_hold_d = rd_data_o;
    stall_d = (rd_valid_i && !rd_ready_o && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    clrv_d = clrv_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (clr_i) begin
        state_d = rmw_v_q ? DRAIN : CLEAR;
        cnt_d = '0;
        clrv_d = clr_value_i;
      end
      DRAIN: state_d = CLEAR;
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        state_d = &cnt_q ? IDLE : CLEAR;
        done_d = &cnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      clrv_q <= '0;
      done_q <= 1'b0;
      rmw_v_q <= 1'b0;
      rmw_bank_q <= '0;
      rmw_row_q <= '0;
      rmw_data_q <= '0;
      rmw_mask_q <= '0;
      rd_v_q <= 1'b0;
      rd_bank_q <= '0;
      rd_hold_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      clrv_q <= clrv_d;
      done_q <= done_d;
      rmw_v_q <= rmw_v_d;
      rmw_bank_q <= rmw_bank_d;
      rmw_row_q <= rmw_row_d;
      rmw_data_q <= rmw_data_d;
      rmw_mask_q <= rmw_mask_d;
      rd_v_q <= rd_v_d;
      rd_bank_q <= rd_bank_d;
      rd_hold_q <= rd_hold_d;
      stall_q <= stall_d;
    end
  end
  for (genvar i = 0; i < NB; i++) begin : g_bank
    gpu_stencil_bank #(.DW(DATA_W), .RW(RW)) u_bank (
      .clk_i(clk_i),
      .en_i(en[i]),
      .we_i(we[i]),
      .addr_i(ba[i]),
      .wdata_i(bw[i]),
      .rdata_o(br[i])
    );
  end
endmodule
